// File: rtl/edge_detect_multi.sv
// -----------------------------------------------------------------------------
// edge_detect_multi
//
// Multi-channel edge detector with glitch filtering and event capture.
// Each channel synchronises an asynchronous strobe and accepts a new level only
// after it has been stable for FILTER_LEN cycles. It then emits one-cycle
// rise/fall pulses. A per-channel mode selects which edges set a sticky flag
// and advance a wrapping event counter.
//
// Ports:
//   clk      rising-edge system clock
//   reset_n  asynchronous, active-low reset
//   s        [N]         raw asynchronous inputs, one per channel
//   mode     [2N]        channel i at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr      [N]         synchronous clear of flag and counter per channel
//   level    [N]         filtered, synchronised level
//   pos      [N]         one-cycle pulse on accepted rising edge
//   neg      [N]         one-cycle pulse on accepted falling edge
//   flag     [N]         sticky event flag
//   count    [N*CNT_W]   event counter, channel i at [(i+1)*CNT_W-1 : i*CNT_W]
//   irq      OR of all flags
// -----------------------------------------------------------------------------
module edge_detect_multi #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       s,
    input  logic [2*N-1:0]     mode,
    input  logic [N-1:0]       clr,
    output logic [N-1:0]       level,
    output logic [N-1:0]       pos,
    output logic [N-1:0]       neg,
    output logic [N-1:0]       flag,
    output logic [N*CNT_W-1:0] count,
    output logic               irq
);

    // Filter counter needs at least one bit even when filtering is disabled.
    localparam int FC_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILTER_LEN - 1);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_r;
            logic                   ss_s;
            logic [FC_W-1:0]        fc_r;
            logic                   level_r;
            logic                   level_d_r;
            logic                   flag_r;
            logic [CNT_W-1:0]       count_r;
            logic                   pos_s;
            logic                   neg_s;
            logic                   ev_s;

            // Synchroniser shift chain for the raw input.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_r <= '0;
                end else begin
                    sync_r <= {sync_r[SYNC_STAGES-2:0], s[i]};
                end
            end

            assign ss_s = sync_r[SYNC_STAGES-1];

            // Stability filter: a differing level must persist FILTER_LEN cycles.
            // Any return to the current level restarts the count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    fc_r    <= '0;
                    level_r <= 1'b0;
                end else if (ss_s == level_r) begin
                    fc_r    <= '0;
                end else if (fc_r == FC_MAX) begin
                    level_r <= ss_s;
                    fc_r    <= '0;
                end else begin
                    fc_r    <= fc_r + FC_W'(1);
                end
            end

            // Delayed copy of the accepted level for edge decoding.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    level_d_r <= 1'b0;
                end else begin
                    level_d_r <= level_r;
                end
            end

            // Pulses are decoded from registers only, so they are glitch-free.
            assign pos_s = level_r & ~level_d_r;
            assign neg_s = ~level_r & level_d_r;
            assign ev_s  = (pos_s & mode[2*i]) | (neg_s & mode[2*i+1]);

            // Sticky flag and wrapping counter; a coincident event beats clear.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    flag_r  <= 1'b0;
                    count_r <= '0;
                end else begin
                    flag_r <= (flag_r & ~clr[i]) | ev_s;
                    if (clr[i] && ev_s) begin
                        count_r <= CNT_W'(1);
                    end else if (clr[i]) begin
                        count_r <= '0;
                    end else if (ev_s) begin
                        count_r <= count_r + CNT_W'(1);
                    end else begin
                        count_r <= count_r;
                    end
                end
            end

            assign level[i]                   = level_r;
            assign pos[i]                     = pos_s;
            assign neg[i]                     = neg_s;
            assign flag[i]                    = flag_r;
            assign count[i*CNT_W +: CNT_W]    = count_r;
        end
    endgenerate

    assign irq = |flag;

endmodule

// File: tb/tb_edge_detect_multi.sv
// -----------------------------------------------------------------------------
// tb_edge_detect_multi
//
// Scoreboard bench. The stimulus pushes the expected pulse records, each with
// the cycle at which the pulse must appear and the flag/count state one cycle
// later. A monitor pops one record every time the DUT shows a pos/neg pulse.
// Non-pulse behaviour (reset, clear, glitch rejection) is checked directly.
// -----------------------------------------------------------------------------
module tb_edge_detect_multi;

    localparam int N  = 4;
    localparam int CW = 3;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    s;
    logic [2*N-1:0]  mode;
    logic [N-1:0]    clr;
    logic [N-1:0]    level;
    logic [N-1:0]    pos;
    logic [N-1:0]    neg;
    logic [N-1:0]    flag;
    logic [N*CW-1:0] count;
    logic            irq;

    edge_detect_multi #(
        .N(4), .SYNC_STAGES(2), .FILTER_LEN(4), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .s(s), .mode(mode), .clr(clr),
        .level(level), .pos(pos), .neg(neg), .flag(flag), .count(count),
        .irq(irq)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  pos;
        logic [3:0]  neg;
        logic [3:0]  level;
        logic [3:0]  flag;
        logic [11:0] count;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend_e;
    bit   pend;
    int   total;
    int   passed;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: number of rising edges since reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [11:0] cnt(input int c3, input int c2, input int c1, input int c0);
        return {c3[2:0], c2[2:0], c1[2:0], c0[2:0]};
    endfunction

    // Monitor: compares a pulse record, then its flag/count one cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (pend) begin
                chk("post_flag", 32'(flag), 32'(pend_e.flag));
                chk("post_count", 32'(count), 32'(pend_e.count));
                chk("post_irq", 32'(irq), 32'(pend_e.flag != 4'b0000));
                pend = 1'b0;
            end
            if ((pos != 4'b0000) || (neg != 4'b0000)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {24'h0, pos, neg}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    chk("pulse_pos", 32'(pos), 32'(e.pos));
                    chk("pulse_neg", 32'(neg), 32'(e.neg));
                    chk("pulse_level", 32'(level), 32'(e.level));
                    pend_e = e;
                    pend   = 1'b1;
                end
            end
        end
    end

    // Drives s[ch] high for len cycles; for accepted pulses pushes the pos and
    // neg records. Total latency from the driving negedge is 6 rising edges.
    task automatic pulse_ch(input int ch, input int len,
                            input logic [3:0] pf, input logic [11:0] pc,
                            input logic [3:0] nf, input logic [11:0] nc);
        exp_t e;
        if (len >= 4) begin
            e.cyc = cyc + 6;       e.pos = 4'(1 << ch); e.neg = 4'b0000;
            e.level = 4'(1 << ch); e.flag = pf;         e.count = pc;
            exp_q.push_back(e);
            e.cyc = cyc + len + 6; e.pos = 4'b0000;     e.neg = 4'(1 << ch);
            e.level = 4'b0000;     e.flag = nf;         e.count = nc;
            exp_q.push_back(e);
        end
        s[ch] = 1'b1;
        repeat (len) @(negedge clk);
        s[ch] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_level"}, 32'(level), 32'h0);
        chk({tag, "_pos"},   32'(pos),   32'h0);
        chk({tag, "_neg"},   32'(neg),   32'h0);
        chk({tag, "_flag"},  32'(flag),  32'h0);
        chk({tag, "_count"}, 32'(count), 32'h0);
        chk({tag, "_irq"},   32'(irq),   32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        reset_n = 1'b0;
        s       = 4'b0000;
        mode    = 8'b01010101;
        clr     = 4'b0000;
        pend    = 1'b0;
        total   = 0;
        passed  = 0;

        #23;
        check_idle("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Latency: s[0] first sampled at edge 10, pos seen at cycle 15.
        repeat (9) @(negedge clk);
        pulse_ch(0, 6, 4'b0001, cnt(0,0,0,1), 4'b0001, cnt(0,0,0,1));

        // Glitch rejection: 3-cycle pulse must leave everything untouched.
        pulse_ch(1, 3, 4'b0000, 12'h0, 4'b0000, 12'h0);
        chk("glitch_level", 32'(level), 32'h0);
        chk("glitch_flag",  32'(flag),  32'h1);
        chk("glitch_count", 32'(count), 32'(cnt(0,0,0,1)));

        // 4-cycle pulse accepted, rising-only mode.
        pulse_ch(1, 4, 4'b0011, cnt(0,0,1,1), 4'b0011, cnt(0,0,1,1));

        // Clear channel 1, then count both edges.
        clr = 4'b0010;
        @(negedge clk);
        clr = 4'b0000;
        @(negedge clk);
        chk("clr1_flag",  32'(flag),  32'h1);
        chk("clr1_count", 32'(count), 32'(cnt(0,0,0,1)));
        mode = 8'b01011101;
        pulse_ch(1, 4, 4'b0011, cnt(0,0,1,1), 4'b0011, cnt(0,0,2,1));

        // Channel 2 falling-only, then off.
        mode = 8'b01101101;
        pulse_ch(2, 5, 4'b0011, cnt(0,0,2,1), 4'b0111, cnt(0,1,2,1));
        mode = 8'b01001101;
        pulse_ch(2, 5, 4'b0111, cnt(0,1,2,1), 4'b0111, cnt(0,1,2,1));

        // Bring channel 3 count to 5.
        for (int k = 1; k <= 5; k++)
            pulse_ch(3, 4, 4'b1111, cnt(k,1,2,1), 4'b1111, cnt(k,1,2,1));

        // Clear coincident with a rising event: set wins, count restarts at 1.
        e.cyc = cyc + 6;  e.pos = 4'b1000; e.neg = 4'b0000;
        e.level = 4'b1000; e.flag = 4'b1111; e.count = cnt(1,1,2,1);
        exp_q.push_back(e);
        e.cyc = cyc + 14; e.pos = 4'b0000; e.neg = 4'b1000;
        e.level = 4'b0000; e.flag = 4'b1111; e.count = cnt(1,1,2,1);
        exp_q.push_back(e);
        s[3] = 1'b1;
        repeat (6) @(negedge clk);
        clr = 4'b1000;
        @(negedge clk);
        clr = 4'b0000;
        @(negedge clk);
        s[3] = 1'b0;
        repeat (12) @(negedge clk);

        // Clear alone.
        clr = 4'b1000;
        @(negedge clk);
        clr = 4'b0000;
        @(negedge clk);
        chk("clr3_flag",  32'(flag),  32'h7);
        chk("clr3_count", 32'(count), 32'(cnt(0,1,2,1)));
        chk("clr3_irq",   32'(irq),   32'h1);
        clr = 4'b0111;
        @(negedge clk);
        clr = 4'b0000;
        @(negedge clk);
        chk("clrall_flag",  32'(flag),  32'h0);
        chk("clrall_count", 32'(count), 32'h0);
        chk("clrall_irq",   32'(irq),   32'h0);

        // Counter wrap on channel 0: 1..7,0,1 with flag held.
        mode = 8'b01010101;
        for (int k = 1; k <= 9; k++)
            pulse_ch(0, 4, 4'b0001, cnt(0,0,0,k % 8), 4'b0001, cnt(0,0,0,k % 8));

        // Reset while the channel 1 filter is mid-count.
        s[1] = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        reset_n = 1'b0;
        s       = 4'b0000;
        #1;
        check_idle("midreset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check_idle("after_reset");

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
